seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DIGIT_CYCLES, default 100000: clocks each digit is lit (1 ms at 100 MHz); legal range 1..2^20-1.
REQ-002 Parameter BLANK_CYCLES, default 1000: clocks all anodes are off between digits; legal range 1..2^20-1.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  scan enable; low blanks the display.
REQ-006 load  input  1  single-cycle strobe capturing value_in.
REQ-007 value_in  input  16  four hex digits; [3:0] is digit 0, [15:12] is digit 3.
REQ-008 anode  output  4  active-low digit enables; anode[n] drives digit n.
REQ-009 cathode  output  7  active-low segments; cathode[6]=a through cathode[0]=g.
REQ-010 digit_sel  output  2  index of the digit currently in its BLANK or SHOW slot.
REQ-011 frame_start  output  1  one-cycle pulse on the first BLANK cycle of digit 0.

Function
REQ-012 FSM states are BLANK and SHOW; BLANK lasts BLANK_CYCLES clocks, then SHOW lasts DIGIT_CYCLES clocks, then BLANK follows with digit_sel incremented modulo 4 (3 wraps to 0).
REQ-013 In BLANK, anode shall be 4'b1111 and cathode 7'b1111111.
REQ-014 In SHOW, exactly one anode bit (anode[digit_sel]) shall be 0, and cathode shall be the glyph of shown[4*digit_sel+3 : 4*digit_sel].
REQ-015 Glyphs are standard hex (0-9, A, b, C, d, E, F); for example, 0 = 7'b0000001, 8 = 7'b0000000, F = 7'b0111000.
REQ-016 anode and cathode are registered, so they change on the same edge as the state transition, with no intra-cycle glitch.
REQ-017 load captures value_in into a pending register and sets the pending flag.
REQ-018 The shown register updates from pending only at the frame boundary (the cycle frame_start asserts), then the pending flag clears; a frame never mixes old and new digits.
REQ-019 When load coincides with the boundary cycle, the loaded value_in goes directly to shown and the pending flag stays clear.
REQ-020 Multiple loads within one frame: the last one wins.
REQ-021 While en is low, the FSM is held in BLANK with digit_sel=0, counters at 0, and frame_start=0; load remains functional.
REQ-022 On en rising, the scan restarts with the full BLANK slot of digit 0, and frame_start pulses in the first cycle with en high.
REQ-023 Cycle counters shall be 20 bits wide and reload on each state change; there is no overflow path.

Reset
REQ-024 Asserting rst immediately sets: anode=4'b1111, cathode=7'b1111111, digit_sel=0, frame_start=0, state=BLANK, counters=0, shown=16'h0000, pending=16'h0000, pending flag=0.
REQ-025 After rst deasserts with en high, the first clock edge starts BLANK of digit 0 and asserts frame_start.
REQ-026 Reset asserted mid-SHOW shall blank the display combinationally via the async clear, with no partial slot resumed.

Configuration
REQ-027 Macro SEG_SCAN_LEADING_ZERO_BLANK_EN defined: in SHOW, a digit n>0 whose nibble and all higher nibbles of shown are 0 keeps its anode high and cathode all-ones; digit 0 always displays, and slot timing is unchanged.
REQ-028 Macro undefined: all four digits always display, including leading zeros.

Structure
REQ-029 Package seg_pkg shall hold the 16-entry glyph constant table, the BLANK/SHOW state enum, and the all-off constants for anode and cathode.
REQ-030 Sub-module seg_hex_glyph (4-bit in, 7-bit out, combinational table lookup) shall be instantiated once.

Verification
REQ-031 rst, then en=1, load value 16'h1234 with DIGIT_CYCLES=4 and BLANK_CYCLES=2 -> anode sequence 1111x2, 1110x4 (glyph 4), 1111x2, 1101x4 (3), ... with frame_start every 24 clocks.
REQ-032 load 16'hABCD mid-frame while 16'h1234 is shown -> remaining digits of the current frame still show 1234; ABCD appears starting from the next frame_start.
REQ-033 load asserted exactly on the frame_start cycle with 16'h00F0 -> the same frame shows 0, F, 0, 0.
REQ-034 en dropped mid-SHOW of digit 2 -> next cycle anode=1111; en re-raised -> frame_start pulses and digit 0 BLANK begins.
REQ-035 rst pulsed mid-SHOW -> outputs all-ones immediately without waiting for a clock edge; shown reads 0000 on the next frame.
REQ-036 With SEG_SCAN_LEADING_ZERO_BLANK_EN, value 16'h0005 -> only digit 0 lights, and digits 1-3 stay off for the whole frame.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: slot state enum,
// counter width, all-off drive levels and the active-low hex glyph table.
package seg_pkg;

   localparam int CNT_W = 20;

   localparam logic [3:0] ANODE_OFF   = 4'b1111;
   localparam logic [6:0] CATHODE_OFF = 7'b1111111;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } seg_state_t;

   // Active-low segments, bit 6 = a ... bit 0 = g.
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0000100,  // 9
      7'b0001000,  // A
      7'b1100000,  // b
      7'b0110001,  // C
      7'b1000010,  // d
      7'b0110000,  // E
      7'b0111000   // F
   };

endpackage

// File: rtl/seg_hex_glyph.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seg_hex_glyph
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// Each digit gets a BLANK slot (all off) followed by a SHOW slot. Displayed
// value is double-buffered and only swapped at the frame boundary.
// Optional macro SEG_SCAN_LEADING_ZERO_BLANK_EN: darkens leading-zero digits
// above digit 0 without changing slot timing.
//
// state | meaning
// BLANK | all anodes/cathodes off for BLANK_CYCLES clocks (also idle/disabled)
// SHOW  | anode[digit_sel] low, glyph of its nibble, for DIGIT_CYCLES clocks
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] value_in,
   output logic [3:0]  anode,
   output logic [6:0]  cathode,
   output logic [1:0]  digit_sel,
   output logic        frame_start
);

   // Counter holds the remaining clocks of the current slot (N..1); zero
   // means the scan is idle and the next enabled edge starts a new frame.
   localparam logic [CNT_W-1:0] DIGIT_LD = CNT_W'(DIGIT_CYCLES);
   localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   seg_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       dsel_nxt;
   logic             fs_nxt;

   logic [15:0]      shown, shown_nxt;
   logic [15:0]      pending, pending_nxt;
   logic             pend_flag, pend_flag_nxt;

   logic [3:0]       nibble_nxt;
   logic [6:0]       glyph_nxt;
   logic             digit_dark;
   logic [3:0]       anode_nxt;
   logic [6:0]       cathode_nxt;

   // Slot sequencing: hold idle while disabled, start a frame on the first
   // enabled edge, otherwise count down and switch slot at terminal count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dsel_nxt  = digit_sel;
      fs_nxt    = 1'b0;
      if (!en) begin
         state_nxt = ST_BLANK;
         cnt_nxt   = '0;
         dsel_nxt  = '0;
      end else if (cnt == '0) begin
         state_nxt = ST_BLANK;
         cnt_nxt   = BLANK_LD;
         dsel_nxt  = '0;
         fs_nxt    = 1'b1;
      end else if (cnt == CNT_ONE) begin
         case (state)
            ST_BLANK: begin
               state_nxt = ST_SHOW;
               cnt_nxt   = DIGIT_LD;
            end
            ST_SHOW: begin
               state_nxt = ST_BLANK;
               cnt_nxt   = BLANK_LD;
               dsel_nxt  = digit_sel + 2'd1;
               fs_nxt    = (digit_sel == 2'd3);
            end
            default: begin
               state_nxt = ST_BLANK;
               cnt_nxt   = '0;
               dsel_nxt  = '0;
            end
         endcase
      end else begin
         cnt_nxt = cnt - CNT_ONE;
      end
   end

   // Display buffer: loads park in pending; the swap happens at the end of the
   // frame_start cycle, and a load on that very cycle bypasses pending.
   always_comb begin
      shown_nxt     = shown;
      pending_nxt   = pending;
      pend_flag_nxt = pend_flag;
      if (load) pending_nxt = value_in;
      if (frame_start) begin
         if (load)           shown_nxt = value_in;
         else if (pend_flag) shown_nxt = pending;
         pend_flag_nxt = 1'b0;
      end else if (load) begin
         pend_flag_nxt = 1'b1;
      end
   end

   assign nibble_nxt = shown_nxt[{dsel_nxt, 2'b00} +: 4];

   seg_hex_glyph u_glyph (
      .nibble (nibble_nxt),
      .glyph  (glyph_nxt)
   );

   // Leading-zero suppression looks at the nibble being shown and all above it.
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
   assign digit_dark = (dsel_nxt != 2'd0) && ((shown_nxt >> {dsel_nxt, 2'b00}) == 16'h0000);
`else
   assign digit_dark = 1'b0;
`endif

   // Drive levels for the upcoming cycle, registered so they switch with the state.
   always_comb begin
      anode_nxt   = ANODE_OFF;
      cathode_nxt = CATHODE_OFF;
      if (state_nxt == ST_SHOW && !digit_dark) begin
         anode_nxt   = ~(4'b0001 << dsel_nxt);
         cathode_nxt = glyph_nxt;
      end
   end

   // Slot state, counter and registered display outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_BLANK;
         cnt         <= '0;
         digit_sel   <= '0;
         frame_start <= 1'b0;
         anode       <= ANODE_OFF;
         cathode     <= CATHODE_OFF;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         digit_sel   <= dsel_nxt;
         frame_start <= fs_nxt;
         anode       <= anode_nxt;
         cathode     <= cathode_nxt;
      end
   end

   // Display value buffers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shown     <= 16'h0000;
         pending   <= 16'h0000;
         pend_flag <= 1'b0;
      end else begin
         shown     <= shown_nxt;
         pending   <= pending_nxt;
         pend_flag <= pend_flag_nxt;
      end
   end

endmodule
